// File: rtl/spi_coeff_writer_pkg.sv
// Shared definitions for the SPI coefficient writer and the FIR engine's SPI
// receiver: the frame state type and the default link geometry.
package spi_coeff_writer_pkg;

    localparam int DEFAULT_WORD_WIDTH = 8;
    localparam int DEFAULT_NUM_WORDS  = 5;
    localparam int DEFAULT_CLK_DIV    = 4;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        HIGH,
        LOW,
        HOLD
    } state_t;

endpackage

// File: rtl/spi_coeff_writer_phase_timer.sv
// spi_phase_timer: times one SPI phase of CLK_DIV system clocks.
// The count reloads whenever the writer changes state, and o_tc marks the
// last cycle of the phase, so every phase lasts exactly CLK_DIV cycles.
module spi_phase_timer #(
    parameter int CLK_DIV = 4
) (
    input  logic i_clk,
    input  logic i_resetN,
    input  logic i_reload,
    output logic o_tc
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] r_count;

    // Reload to CLK_DIV-1 at a phase start, then count down and park at zero.
    always_ff @(posedge i_clk or negedge i_resetN) begin
        if (!i_resetN) begin
            r_count <= CW'(CLK_DIV - 1);
        end else if (i_reload) begin
            r_count <= CW'(CLK_DIV - 1);
        end else if (r_count != '0) begin
            r_count <= r_count - CW'(1);
        end
    end

    assign o_tc = (r_count == '0);

endmodule

// File: rtl/spi_coeff_writer.sv
// spi_coeff_writer: SPI mode-0 initiator that sends a block of FIR
// coefficient words, word 0 first and MSB first, one frame per start request.
// Optional feature macro: SPI_COEFF_WRITER_PARITY_EN appends one even-parity
// bit covering all data bits to the end of the frame.
module spi_coeff_writer
    import spi_coeff_writer_pkg::*;
#(
    parameter int WORD_WIDTH = DEFAULT_WORD_WIDTH,
    parameter int NUM_WORDS  = DEFAULT_NUM_WORDS,
    parameter int CLK_DIV    = DEFAULT_CLK_DIV
) (
    input  logic                            clk,
    input  logic                            resetN,
    input  logic                            start,
    input  logic [NUM_WORDS*WORD_WIDTH-1:0] words,
    output logic                            busy,
    output logic                            done,
    output logic                            cs,
    output logic                            mosi,
    output logic                            spiClk
);

    localparam int DATA_BITS = NUM_WORDS * WORD_WIDTH;
`ifdef SPI_COEFF_WRITER_PARITY_EN
    localparam int FRAME_BITS = DATA_BITS + 1;
`else
    localparam int FRAME_BITS = DATA_BITS;
`endif
    localparam int CNT_W = $clog2(FRAME_BITS + 1);

    state_t                r_state;
    state_t                w_stateNext;
    logic [FRAME_BITS-1:0] r_shift;
    logic [FRAME_BITS-1:0] w_shiftInit;
    logic [FRAME_BITS-1:0] w_shiftNext;
    logic [CNT_W-1:0]      r_bitCnt;
    logic                  w_accept;
    logic                  w_advance;
    logic                  w_reload;
    logic                  w_tc;
    logic                  r_cs;
    logic                  r_spiClk;
    logic                  r_mosi;
    logic                  r_busy;
    logic                  r_done;

    spi_phase_timer #(
        .CLK_DIV (CLK_DIV)
    ) u_phaseTimer (
        .i_clk    (clk),
        .i_resetN (resetN),
        .i_reload (w_reload),
        .o_tc     (w_tc)
    );

    // Arrange the words in transmit order so the frame always leaves from the MSB.
    always_comb begin
        w_shiftInit = '0;
        for (int i = 0; i < NUM_WORDS; i++) begin
            w_shiftInit[FRAME_BITS-1-i*WORD_WIDTH -: WORD_WIDTH] = words[i*WORD_WIDTH +: WORD_WIDTH];
        end
`ifdef SPI_COEFF_WRITER_PARITY_EN
        w_shiftInit[0] = ^words;
`endif
        w_shiftNext = r_shift << 1;
    end

    // Phase sequencing: each non-idle state lasts one timer period.
    always_comb begin
        w_stateNext = r_state;
        w_accept    = 1'b0;
        w_advance   = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_stateNext = SETUP;
                    w_accept    = 1'b1;
                end
            end
            SETUP: begin
                if (w_tc) w_stateNext = HIGH;
            end
            HIGH: begin
                if (w_tc) begin
                    if (r_bitCnt != '0) begin
                        w_stateNext = LOW;
                        w_advance   = 1'b1;
                    end else begin
                        w_stateNext = HOLD;
                    end
                end
            end
            LOW: begin
                if (w_tc) w_stateNext = HIGH;
            end
            HOLD: begin
                if (w_tc) w_stateNext = IDLE;
            end
            default: w_stateNext = IDLE;
        endcase
        w_reload = (w_stateNext != r_state);
    end

    // State register.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Link outputs are registered from the next state so nothing is combinational from inputs.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_shift  <= '0;
            r_bitCnt <= '0;
            r_cs     <= 1'b1;
            r_spiClk <= 1'b0;
            r_mosi   <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_cs     <= (w_stateNext == IDLE);
            r_spiClk <= (w_stateNext == HIGH);
            r_busy   <= (w_stateNext != IDLE);
            r_done   <= (r_state == HOLD) && (w_stateNext == IDLE);
            if (w_accept) begin
                r_shift  <= w_shiftInit;
                r_bitCnt <= CNT_W'(FRAME_BITS - 1);
                r_mosi   <= w_shiftInit[FRAME_BITS-1];
            end else if (w_advance) begin
                r_shift  <= w_shiftNext;
                r_bitCnt <= r_bitCnt - CNT_W'(1);
                r_mosi   <= w_shiftNext[FRAME_BITS-1];
            end else if (w_stateNext == HOLD || w_stateNext == IDLE) begin
                r_mosi   <= 1'b0;
            end
        end
    end

    assign cs     = r_cs;
    assign spiClk = r_spiClk;
    assign mosi   = r_mosi;
    assign busy   = r_busy;
    assign done   = r_done;

endmodule

// File: tb/tb_spi_coeff_writer.sv
// Testbench for spi_coeff_writer: a 5-word instance at CLK_DIV=2 and a
// single-word instance at CLK_DIV=1, checked against a bit-list model.
module tb_spi_coeff_writer;

    logic        clk;
    logic        resetN;
    logic        startA;
    logic        startC;
    logic [39:0] wordsA;
    logic [7:0]  wordsC;
    logic        busyA, doneA, csA, mosiA, spiA;
    logic        busyC, doneC, csC, mosiC, spiC;

    logic        sel;
    logic        obsCs, obsSpi, obsMosi, obsBusy, obsDone;

    int          vectors;
    int          miscompares;

    logic [63:0] capBits;
    int          capCount;
    int          csLowCnt;
    int          spiHighCnt;
    logic        timedOut;
    logic        aborted;
    logic        firstCs, firstBusy, firstMosi;
    logic        doneCs, donePrevCs, doneBusy;
    int          disturbAt;
    int          abortAt;

    spi_coeff_writer #(
        .WORD_WIDTH (8),
        .NUM_WORDS  (5),
        .CLK_DIV    (2)
    ) dutA (
        .clk    (clk),
        .resetN (resetN),
        .start  (startA),
        .words  (wordsA),
        .busy   (busyA),
        .done   (doneA),
        .cs     (csA),
        .mosi   (mosiA),
        .spiClk (spiA)
    );

    spi_coeff_writer #(
        .WORD_WIDTH (8),
        .NUM_WORDS  (1),
        .CLK_DIV    (1)
    ) dutC (
        .clk    (clk),
        .resetN (resetN),
        .start  (startC),
        .words  (wordsC),
        .busy   (busyC),
        .done   (doneC),
        .cs     (csC),
        .mosi   (mosiC),
        .spiClk (spiC)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Route the instance under observation onto one set of monitor signals.
    always_comb begin
        obsCs   = sel ? csC   : csA;
        obsSpi  = sel ? spiC  : spiA;
        obsMosi = sel ? mosiC : mosiA;
        obsBusy = sel ? busyC : busyA;
        obsDone = sel ? doneC : doneA;
    end

    // Reference: the frame is the word bits listed word 0 first, MSB first, plus optional even parity.
    function automatic void modelFrame(input logic [63:0] w, input int nWords,
                                       output logic [63:0] expBits, output int nBits);
        int ones;
        expBits = '0;
        nBits   = 0;
        ones    = 0;
        for (int i = 0; i < nWords; i++) begin
            for (int b = 7; b >= 0; b--) begin
                expBits = {expBits[62:0], w[i*8+b]};
                nBits++;
                ones += int'(w[i*8+b]);
            end
        end
`ifdef SPI_COEFF_WRITER_PARITY_EN
        expBits = {expBits[62:0], ones[0]};
        nBits++;
`endif
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic useC, input logic [39:0] w);
        @(negedge clk);
        sel = useC;
        if (useC) begin
            wordsC = w[7:0];
            startC = 1'b1;
        end else begin
            wordsA = w;
            startA = 1'b1;
        end
        @(negedge clk);
        startA = 1'b0;
        startC = 1'b0;
    endtask

    // Watch one frame starting in the cycle after acceptance, until done, abort or budget.
    task automatic captureFrame(input int budget);
        logic prevSpi;
        logic prevCs;
        logic ended;
        capBits    = '0;
        capCount   = 0;
        csLowCnt   = 0;
        spiHighCnt = 0;
        aborted    = 1'b0;
        ended      = 1'b0;
        doneCs     = 1'b0;
        donePrevCs = 1'b1;
        doneBusy   = 1'b1;
        firstCs    = obsCs;
        firstBusy  = obsBusy;
        firstMosi  = obsMosi;
        prevSpi    = 1'b0;
        prevCs     = 1'b1;
        for (int k = 0; k < budget; k++) begin
            if (k == disturbAt) begin
                startA = 1'b1;
                wordsA = 40'({$urandom(), $urandom()});
            end
            if (k == disturbAt + 1) startA = 1'b0;
            if (obsDone) begin
                doneCs     = obsCs;
                donePrevCs = prevCs;
                doneBusy   = obsBusy;
                ended      = 1'b1;
                break;
            end
            if (!obsCs) csLowCnt++;
            if (obsSpi) spiHighCnt++;
            if (obsSpi && !prevSpi) begin
                capBits = {capBits[62:0], obsMosi};
                capCount++;
                if (capCount == abortAt) begin
                    resetN  = 1'b0;
                    #1;
                    aborted = 1'b1;
                    ended   = 1'b1;
                    break;
                end
            end
            prevSpi = obsSpi;
            prevCs  = obsCs;
            @(negedge clk);
        end
        timedOut = !ended;
    endtask

    task automatic checkFrame(input string tag, input logic [63:0] w, input int nWords, input int cd);
        logic [63:0] expBits;
        int          nBits;
        modelFrame(w, nWords, expBits, nBits);
        checkOutput({tag, "_timeout"}, 64'(timedOut), 64'(0));
        checkOutput({tag, "_bits"}, capBits, expBits);
        checkOutput({tag, "_nbits"}, 64'(capCount), 64'(nBits));
        checkOutput({tag, "_csLow"}, 64'(csLowCnt), 64'((2 * nBits + 1) * cd));
        checkOutput({tag, "_spiHigh"}, 64'(spiHighCnt), 64'(nBits * cd));
        checkOutput({tag, "_first"}, 64'({firstCs, firstBusy, firstMosi}),
                    64'({1'b0, 1'b1, expBits[nBits-1]}));
        checkOutput({tag, "_doneEdge"}, 64'({doneCs, donePrevCs, doneBusy}), 64'(3'b100));
    endtask

    initial begin
        logic [39:0] wOrig;
        logic        sawDone;

        vectors     = 0;
        miscompares = 0;
        sel         = 1'b0;
        resetN      = 1'b0;
        startA      = 1'b0;
        startC      = 1'b0;
        wordsA      = '0;
        wordsC      = '0;
        disturbAt   = -1;
        abortAt     = 0;

        // Reset values on both instances.
        repeat (3) @(negedge clk);
        checkOutput("rst_A", 64'({csA, spiA, mosiA, busyA, doneA}), 64'(5'b10000));
        checkOutput("rst_C", 64'({csC, spiC, mosiC, busyC, doneC}), 64'(5'b10000));
        resetN = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("idle_A", 64'({csA, spiA, mosiA, busyA, doneA}), 64'(5'b10000));

        // Directed frame from the reference pattern.
        applyStimulus(1'b0, 40'hFF_00_A5_80_01);
        captureFrame(1000);
        checkFrame("dir", 64'(40'hFF_00_A5_80_01), 5, 2);
        @(negedge clk);
        checkOutput("dir_donePulse", 64'({obsDone, obsCs, obsBusy}), 64'(3'b010));

        // Random frames.
        for (int n = 0; n < 3; n++) begin
            wOrig = 40'({$urandom(), $urandom()});
            applyStimulus(1'b0, wOrig);
            captureFrame(1000);
            checkFrame("rnd", 64'(wOrig), 5, 2);
        end

        // Start pulse and new words mid-frame must not disturb the frame in flight.
        wOrig = 40'({$urandom(), $urandom()});
        applyStimulus(1'b0, wOrig);
        disturbAt = 20;
        captureFrame(1000);
        disturbAt = -1;
        checkFrame("busyStart", 64'(wOrig), 5, 2);
        repeat (3) @(negedge clk);
        checkOutput("busyStart_idle", 64'({obsCs, obsBusy}), 64'(2'b10));

        // Reset at the 17th rising spiClk aborts without done.
        wOrig = 40'({$urandom(), $urandom()});
        applyStimulus(1'b0, wOrig);
        abortAt = 17;
        captureFrame(1000);
        abortAt = 0;
        checkOutput("abort_hit", 64'(aborted), 64'(1));
        checkOutput("abort_outs", 64'({obsCs, obsSpi, obsMosi, obsBusy, obsDone}), 64'(5'b10000));
        sawDone = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (obsDone) sawDone = 1'b1;
        end
        checkOutput("abort_noDone", 64'(sawDone), 64'(0));
        resetN = 1'b1;
        wOrig = 40'({$urandom(), $urandom()});
        applyStimulus(1'b0, wOrig);
        captureFrame(1000);
        checkFrame("afterAbort", 64'(wOrig), 5, 2);

        // Single word 0xC3 at CLK_DIV=1.
        applyStimulus(1'b1, 40'hC3);
        captureFrame(200);
        checkFrame("c3", 64'h00C3, 1, 1);

        // Start held high: back-to-back frames with a single cs-high cycle between them.
        @(negedge clk);
        sel    = 1'b1;
        wordsC = 8'($urandom());
        startC = 1'b1;
        @(negedge clk);
        for (int f = 0; f < 3; f++) begin
            captureFrame(200);
            checkFrame("b2b", 64'(wordsC), 1, 1);
            @(negedge clk);
            checkOutput("b2b_gap", 64'({obsCs, obsBusy}), 64'(2'b01));
        end
        startC = 1'b0;
        captureFrame(200);
        checkFrame("b2bLast", 64'(wordsC), 1, 1);
        @(negedge clk);
        checkOutput("b2b_stop", 64'({obsCs, obsBusy, obsDone}), 64'(3'b100));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/spi_coeff_writer.md
# spi_coeff_writer

SPI initiator that serialises a block of FIR coefficient words onto a `cs`/`mosi`/`spiClk` link, i.e. the sending end of the coefficient-load port the FIR engine listens on. It sits in on-board self-test and loader tops, where it drives the engine's SPI inputs from locally held words such as switches or a ROM. It produces one frame per `start` request and signals completion with a single-cycle `done`.

## Interface
- `WORD_WIDTH`, default 8: bits per coefficient word.
- `NUM_WORDS`, default 5: words per frame.
- `CLK_DIV`, default 4: `clk` cycles per `spiClk` half-period (≥1).
- `clk`  input  1  system clock.
- `resetN`  input  1  asynchronous, active-low reset.
- `start`  input  1  frame request; sampled only in IDLE.
- `words`  input  NUM_WORDS*WORD_WIDTH  coefficient words. Word 0 occupies bits [WORD_WIDTH-1:0]. Latched on accepted `start`.
- `busy`  output  1  high from the cycle after an accepted `start` until `done`.
- `done`  output  1  one-cycle pulse at frame end.
- `cs`  output  1  chip select, active-low.
- `mosi`  output  1  serial data, MSB first, word 0 first.
- `spiClk`  output  1  SPI clock, mode 0 (idle low; receiver samples on rising edge).

## Operation
- States: IDLE, SETUP, HIGH, LOW, HOLD.
- Reset values (asynchronous, immediate): `cs`=1, `spiClk`=0, `mosi`=0, `busy`=0, `done`=0, state IDLE, bit counter 0.
- IDLE + `start`=1:
  - Latch `words` into the shift register.
  - Next cycle: `cs`=0, `mosi`=first bit, `busy`=1, go to SETUP.
- SETUP (CLK_DIV cycles, `spiClk`=0) → HIGH.
- HIGH (CLK_DIV cycles, `spiClk`=1, `mosi` stable):
  - If bits remain → LOW.
  - Otherwise → HOLD.
- LOW (CLK_DIV cycles, `spiClk`=0). `mosi` advances to the next bit on the first LOW cycle. → HIGH.
- HOLD (CLK_DIV cycles, `spiClk`=0, `mosi`=0) → IDLE. The first IDLE cycle has `cs`=1, `done`=1 and `busy`=0.
- Frame bits B = NUM_WORDS*WORD_WIDTH. Bit index is counted with a counter of width $clog2(B+1).
- `start` while `busy`=1 is ignored. `words` changes during a frame have no effect.
- `start` in the `done` cycle is accepted, because the state is IDLE. `cs` is then high for exactly 1 cycle between frames.
- `resetN` low mid-frame aborts the frame with no `done`. The receiver sees `cs` rise with a partial frame.

## Timing
- Accepted `start` in cycle t:
  - `cs` low during cycles t+1 … t+(2B+1)*CLK_DIV.
  - `done` in cycle t+(2B+1)*CLK_DIV+1.
- All outputs are registered, so there are no combinational paths from inputs.
- `mosi` setup before each rising `spiClk` = CLK_DIV cycles; hold after = CLK_DIV cycles.
- The phase counter reloads at every state change. CLK_DIV=1 must work, giving an `spiClk` of clk/2.

## Configuration
- `SPI_COEFF_WRITER_PARITY_EN` defined:
  - Appends one even-parity bit (XOR of all B data bits) after the last data bit, so frame length is B+1 bits.
  - Timing formulas use B+1.
- Not defined: exactly B bits, and no parity logic is compiled.

## Structure
- `spi_coeff_writer_pkg` holds:
  - the state enum type;
  - default constants for WORD_WIDTH, NUM_WORDS and CLK_DIV, shared with the FIR engine's SPI receiver.
- One sub-module, `spi_phase_timer`: a CLK_DIV down-counter with reload and a terminal-count pulse, used for every phase.

## Test plan
- Defaults with CLK_DIV=2; `words` = 0x01,0x80,0xA5,0x00,0xFF; one `start` pulse:
  - `mosi` sampled on rising `spiClk` = 00000001 10000000 10100101 00000000 11111111.
  - `cs` low for 162 cycles; 40 rising edges.
  - `done` one cycle after `cs` rises.
- Same stimulus with `SPI_COEFF_WRITER_PARITY_EN`: 41st sampled bit = 0 (14 ones); `cs` low for 166 cycles.
- `start` held high continuously with CLK_DIV=1: back-to-back frames, `cs` high exactly 1 cycle between them, `done` once per frame.
- `start` pulses while `busy`, with `words` changed mid-frame: no restart, and the transmitted bits match the words latched at the original `start`.
- `resetN` asserted at the 17th rising `spiClk`: same cycle `cs`=1, `spiClk`=0, `mosi`=0; no `done`. After release, a new `start` sends a full, correct frame.
- CLK_DIV=1, NUM_WORDS=1, WORD_WIDTH=8, word 0xC3:
  - Bits 11000011.
  - `cs` low 17 cycles.
  - `spiClk` high exactly one cycle per bit.
